// File: rtl/cr_prefix_fe_seq.sv
`default_nettype none
// ============================================================================
// Module   : cr_prefix_fe_seq
// Purpose  : Sequencer and configuration controller for the prefix
//            feature-extraction compare array. Registers the incoming
//            character stream onto char_in/char_valid, holds a shadow and an
//            active bank of per-unit compare configuration, swaps the banks
//            only at a block boundary once the compare pipeline has drained,
//            and reports the length of each block.
// Ports    : clk, rst (sync, active-high)
//            cfg_wr/cfg_addr/cfg_wdata : shadow entry write
//            cfg_commit/cfg_busy/cfg_err : swap request / pending / drop pulse
//            in_valid/in_ready/in_char/in_eob : character stream input
//            char_in/char_valid : registered feed to the compare units
//            match_val/cmp_type/use_prior/no_delay : active bank, unit i at slice i
//            active_bank : toggles on each swap
//            blk_len/blk_len_valid : completed block length, one-cycle pulse
// Revision : 1.0 - initial release
// ============================================================================
module cr_prefix_fe_seq #(
  parameter int NUM_CMP   = 16,
  parameter int DRAIN_CYC = 2,
  parameter int LEN_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_wr,
  input  logic [$clog2(NUM_CMP)-1:0] cfg_addr,
  input  logic [11:0]                cfg_wdata,
  input  logic                       cfg_commit,
  output logic                       cfg_busy,
  output logic                       cfg_err,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_char,
  input  logic                       in_eob,
  output logic [7:0]                 char_in,
  output logic                       char_valid,
  output logic [NUM_CMP*8-1:0]       match_val,
  output logic [NUM_CMP*2-1:0]       cmp_type,
  output logic [NUM_CMP-1:0]         use_prior,
  output logic [NUM_CMP-1:0]         no_delay,
  output logic                       active_bank,
  output logic [LEN_W-1:0]           blk_len,
  output logic                       blk_len_valid
);

  localparam int              DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0]   DRAIN_LOAD = DW'(DRAIN_CYC - 1);
  localparam logic [LEN_W-1:0] LEN_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    SWAP   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             commit_pend;
  logic             commit_pend_nxt;
  logic             ready_nxt;
  logic             drain_load;
  logic [DW-1:0]    drain_cnt;
  logic [LEN_W-1:0] len_cnt;
  logic [LEN_W-1:0] len_inc;
  logic             accept;

  // Entry layout: {no_delay, use_prior, cmp_type[1:0], match_val[7:0]}
  logic [11:0] shadow [NUM_CMP];
  logic [11:0] active [NUM_CMP];

  assign accept   = in_valid & in_ready;
  assign cfg_busy = commit_pend;
  assign len_inc  = (len_cnt == LEN_MAX) ? len_cnt : len_cnt + LEN_W'(1);

  // A commit issued while one is already pending is simply absorbed.
  always_comb begin
    commit_pend_nxt = commit_pend;
    if (state == SWAP) begin
      commit_pend_nxt = 1'b0;
    end else if (cfg_commit) begin
      commit_pend_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    drain_load = 1'b0;
    case (state)
      IDLE: begin
        if (commit_pend) begin
          state_nxt  = DRAIN;
          drain_load = 1'b1;
        end else if (accept && !in_eob) begin
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        // A commit raised mid-block only takes effect at the eob.
        if (accept && in_eob) begin
          if (commit_pend) begin
            state_nxt  = DRAIN;
            drain_load = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          state_nxt = commit_pend ? SWAP : IDLE;
        end
      end
      SWAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // in_ready is registered: derive next cycle's value from next state,
    // so there is no combinational path from in_valid.
    ready_nxt = (state_nxt == STREAM) || ((state_nxt == IDLE) && !commit_pend_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_pend   <= 1'b0;
      in_ready      <= 1'b0;
      cfg_err       <= 1'b0;
      drain_cnt     <= '0;
      char_in       <= '0;
      char_valid    <= 1'b0;
      len_cnt       <= '0;
      blk_len       <= '0;
      blk_len_valid <= 1'b0;
      active_bank   <= 1'b0;
      for (int i = 0; i < NUM_CMP; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      commit_pend <= commit_pend_nxt;
      in_ready    <= ready_nxt;

      // Shadow writes are frozen while a swap is pending so the committed
      // image cannot change under the swap.
      cfg_err <= cfg_wr & commit_pend;
      if (cfg_wr && !commit_pend) begin
        shadow[cfg_addr] <= cfg_wdata;
      end

      if (state == SWAP) begin
        for (int i = 0; i < NUM_CMP; i++) begin
          active[i] <= shadow[i];
        end
        active_bank <= ~active_bank;
      end

      if (drain_load) begin
        drain_cnt <= DRAIN_LOAD;
      end else if ((state == DRAIN) && (drain_cnt != '0)) begin
        drain_cnt <= drain_cnt - DW'(1);
      end

      char_valid <= accept;
      if (accept) begin
        char_in <= in_char;
      end

      blk_len_valid <= accept & in_eob;
      if (accept) begin
        if (in_eob) begin
          blk_len <= len_inc;
          len_cnt <= '0;
        end else begin
          len_cnt <= len_inc;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_CMP; i++) begin : g_unit
    assign match_val[i*8 +: 8] = active[i][7:0];
    assign cmp_type[i*2 +: 2]  = active[i][9:8];
    assign use_prior[i]        = active[i][10];
    assign no_delay[i]         = active[i][11];
  end

endmodule
`default_nettype wire

// File: tb/tb_cr_prefix_fe_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cr_prefix_fe_seq
// Purpose  : Self-checking bench for cr_prefix_fe_seq. Accepted characters
//            and expected block lengths are queued when the stream is driven
//            and compared when the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cr_prefix_fe_seq;

  localparam int NUM_CMP   = 16;
  localparam int DRAIN_CYC = 2;
  localparam int LEN_W     = 16;
  localparam int LEN_MAX   = (1 << LEN_W) - 1;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       cfg_wr = 1'b0;
  logic [$clog2(NUM_CMP)-1:0] cfg_addr = '0;
  logic [11:0]                cfg_wdata = '0;
  logic                       cfg_commit = 1'b0;
  logic                       cfg_busy;
  logic                       cfg_err;
  logic                       in_valid = 1'b0;
  logic                       in_ready;
  logic [7:0]                 in_char = '0;
  logic                       in_eob = 1'b0;
  logic [7:0]                 char_in;
  logic                       char_valid;
  logic [NUM_CMP*8-1:0]       match_val;
  logic [NUM_CMP*2-1:0]       cmp_type;
  logic [NUM_CMP-1:0]         use_prior;
  logic [NUM_CMP-1:0]         no_delay;
  logic                       active_bank;
  logic [LEN_W-1:0]           blk_len;
  logic                       blk_len_valid;

  cr_prefix_fe_seq #(
    .NUM_CMP   (NUM_CMP),
    .DRAIN_CYC (DRAIN_CYC),
    .LEN_W     (LEN_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_wr        (cfg_wr),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .cfg_commit    (cfg_commit),
    .cfg_busy      (cfg_busy),
    .cfg_err       (cfg_err),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_char       (in_char),
    .in_eob        (in_eob),
    .char_in       (char_in),
    .char_valid    (char_valid),
    .match_val     (match_val),
    .cmp_type      (cmp_type),
    .use_prior     (use_prior),
    .no_delay      (no_delay),
    .active_bank   (active_bank),
    .blk_len       (blk_len),
    .blk_len_valid (blk_len_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] char_q[$];
  int         len_q[$];
  int         mlen       = 0;
  bit         prev_acc   = 1'b0;
  int         len_pulses = 0;

  always @(negedge clk) begin
    if (rst) begin
      char_q.delete();
      len_q.delete();
      mlen     = 0;
      prev_acc = 1'b0;
    end else begin
      check_val("char_valid", char_valid, prev_acc);
      if (char_valid) begin
        if (char_q.size() == 0) check_val("char_q_underflow", 1, 0);
        else check_val("char_in", char_in, char_q.pop_front());
      end
      if (blk_len_valid) begin
        len_pulses++;
        if (len_q.size() == 0) check_val("len_q_underflow", 1, 0);
        else check_val("blk_len_sb", blk_len, len_q.pop_front());
      end
      if (in_valid && in_ready) begin
        char_q.push_back(in_char);
        if (in_eob) begin
          len_q.push_back((mlen == LEN_MAX) ? LEN_MAX : mlen + 1);
          mlen = 0;
        end else if (mlen != LEN_MAX) begin
          mlen++;
        end
      end
      prev_acc = in_valid && in_ready;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives n characters; eob on the last one if with_eob. cfg_commit pulses
  // alongside character index commit_at. Returns cycles spent stalled.
  task automatic send_block(input int n, input int commit_at, input bit with_eob,
                            output int stalls);
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      int guard;
      bit acc;
      guard      = 0;
      acc        = 1'b0;
      in_valid   = 1'b1;
      in_char    = 8'($urandom);
      in_eob     = with_eob && (i == n - 1);
      cfg_commit = (i == commit_at);
      while (!acc && guard < 64) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        cfg_commit = 1'b0;
        if (!acc) begin
          stalls++;
          guard++;
        end
      end
      if (!acc) check_val("send_timeout", 0, 1);
    end
    in_valid = 1'b0;
    in_eob   = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_eob     = 1'b0;
    cfg_wr     = 1'b0;
    cfg_commit = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check_val({tag, "_in_ready"}, in_ready, 0);
    check_val({tag, "_char_valid"}, char_valid, 0);
    check_val({tag, "_char_in"}, char_in, 0);
    check_val({tag, "_blk_len"}, blk_len, 0);
    check_val({tag, "_blk_len_valid"}, blk_len_valid, 0);
    check_val({tag, "_cfg_busy"}, cfg_busy, 0);
    check_val({tag, "_cfg_err"}, cfg_err, 0);
    check_val({tag, "_active_bank"}, active_bank, 0);
    check_val({tag, "_cfg_outs"}, |{match_val, cmp_type, use_prior, no_delay}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val({tag, "_ready_first"}, in_ready, 0);
    @(negedge clk);
    check_val({tag, "_ready_rise"}, in_ready, 1);
    tick();
  endtask

  task automatic write_cfg(input int addr, input logic [11:0] data);
    cfg_wr    = 1'b1;
    cfg_addr  = addr[$clog2(NUM_CMP)-1:0];
    cfg_wdata = data;
    tick();
    cfg_wr    = 1'b0;
  endtask

  task automatic commit_and_wait(output int busy_cyc, output bit early, output int errs);
    busy_cyc   = 0;
    early      = 1'b0;
    errs       = 0;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    @(negedge clk);
    while (cfg_busy && busy_cyc < 20) begin
      busy_cyc++;
      if (cfg_err) errs++;
      if (match_val[31:24] != 8'h00 && active_bank == 1'b0) early = 1'b1;
      @(negedge clk);
    end
    if (cfg_err) errs++;
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int  st;
    int  busy_cyc;
    int  errs;
    int  low_cnt;
    int  p0;
    bit  early;

    // Reset and first commit from IDLE
    do_reset("rst0");
    write_cfg(3, {1'b0, 1'b1, 2'b01, 8'h41});
    commit_and_wait(busy_cyc, early, errs);
    check_val("t1_busy_cycles", busy_cyc, DRAIN_CYC + 2);
    check_val("t1_early_swap", early, 0);
    check_val("t1_match3", match_val[31:24], 8'h41);
    check_val("t1_use_prior3", use_prior[3], 1);
    check_val("t1_cmp_type3", cmp_type[7:6], 2'b01);
    check_val("t1_no_delay3", no_delay[3], 0);
    check_val("t1_match2", match_val[23:16], 8'h00);
    check_val("t1_bank", active_bank, 1);

    // 5-character block, no commit
    p0 = len_pulses;
    send_block(5, -1, 1'b1, st);
    check_val("t2_stalls", st, 0);
    repeat (3) tick();
    check_val("t2_pulses", len_pulses - p0, 1);
    check_val("t2_blk_len", blk_len, 5);

    // Commit on 2nd character of a 4-character block
    write_cfg(5, 12'h877);
    send_block(4, 1, 1'b1, st);
    check_val("t3_stalls", st, 0);
    low_cnt = 0;
    for (int k = 0; k < DRAIN_CYC + 2; k++) begin
      @(negedge clk);
      if (!in_ready) low_cnt++;
      if (k == DRAIN_CYC) check_val("t3_pre_swap", match_val[47:40], 8'h00);
      if (k == DRAIN_CYC + 1) begin
        check_val("t3_post_swap", match_val[47:40], 8'h77);
        check_val("t3_no_delay5", no_delay[5], 1);
        check_val("t3_bank", active_bank, 0);
        check_val("t3_busy", cfg_busy, 0);
      end
    end
    check_val("t3_ready_low", low_cnt, DRAIN_CYC + 1);
    tick();

    // Write dropped while busy
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    cfg_wr     = 1'b1;
    cfg_addr   = '0;
    cfg_wdata  = 12'hFAB;
    tick();
    cfg_wr = 1'b0;
    errs   = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cfg_err) errs++;
    end
    check_val("t4_err_pulses", errs, 1);
    check_val("t4_bank", active_bank, 1);
    check_val("t4_match0", match_val[7:0], 8'h00);
    check_val("t4_busy", cfg_busy, 0);
    tick();
    commit_and_wait(busy_cyc, early, errs);
    check_val("t4_shadow0", {no_delay[0], use_prior[0], cmp_type[1:0], match_val[7:0]}, 12'h000);
    check_val("t4_keep5", match_val[47:40], 8'h77);
    check_val("t4_errs2", errs, 0);

    // Saturating length counter
    send_block(LEN_MAX + 4, -1, 1'b1, st);
    repeat (3) tick();
    check_val("t5_sat_len", blk_len, 16'hFFFF);
    send_block(1, -1, 1'b1, st);
    repeat (3) tick();
    check_val("t5_one_len", blk_len, 1);

    // Reset mid-block with a commit pending
    send_block(2, 0, 1'b0, st);
    @(negedge clk);
    check_val("t6_busy_before", cfg_busy, 1);
    tick();
    do_reset("rst1");
    send_block(2, -1, 1'b1, st);
    repeat (3) tick();
    check_val("t6_blk_len", blk_len, 2);
    commit_and_wait(busy_cyc, early, errs);
    check_val("t6_bank_zero", |{match_val, cmp_type, use_prior, no_delay}, 0);
    check_val("t6_bank", active_bank, 1);

    repeat (3) tick();
    check_val("sb_char_empty", char_q.size(), 0);
    check_val("sb_len_empty", len_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, %0d tests run", n_tests);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
